// File: rtl/regs_dump_pkg.sv
// Shared defaults and FSM state encoding for the register-file dump engine.
package regs_dump_pkg;

  localparam int unsigned DEF_ADDR_W    = 5;
  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_LAST_ADDR = 31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/regs_dump.sv
// Walks an external register file from address 0 to LAST_ADDR and streams
// each captured word out over a valid/ready handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; counter parked at 0
// READ    | r_addr = counter, word and address captured on the edge
// SEND    | captured word presented until accepted (or abort)
// FIN     | one-cycle done pulse, then back to IDLE
module regs_dump
  import regs_dump_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned LAST_ADDR = DEF_LAST_ADDR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] r_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nx;
  logic              capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // The captured word is frozen outside READ so later register-file writes
  // never leak into a word that is already being presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      cnt <= cnt_nx;
      if (capture) begin
        out_addr <= cnt;
        out_data <= r_data;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_READ;
          cnt_nx   = '0;
        end
      end
      ST_READ: begin
        if (abort) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          state_nx = ST_SEND;
          capture  = 1'b1;
        end
      end
      ST_SEND: begin
        // abort wins over a transfer landing on the same edge
        if (abort) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else if (out_ready) begin
          if (cnt == LAST) begin
            state_nx = ST_FIN;
          end else begin
            state_nx = ST_READ;
            cnt_nx   = cnt + 1'b1;
          end
        end
      end
      ST_FIN: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign r_addr    = cnt;
  assign out_valid = (state == ST_SEND);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FIN);

endmodule

// File: tb/tb_regs_dump.sv
// Randomized bench for regs_dump against a scan-order reference model
// (words 0..LAST in order, data snapshotted from the register file).
module tb_regs_dump;

  logic        clk;
  logic        rst_n;
  logic        start, abort, out_ready;
  logic [4:0]  r_addr, out_addr;
  logic [31:0] r_data, out_data;
  logic        out_valid, busy, done;

  logic        start2, abort2, out_ready2;
  logic [4:0]  r_addr2, out_addr2;
  logic [31:0] r_data2, out_data2;
  logic        out_valid2, busy2, done2;

  logic [31:0] regfile [32];

  int vectors = 0;
  int miscompares = 0;

  // team register file: address 0 always reads 0
  assign r_data  = (r_addr  == 5'd0) ? 32'h0 : regfile[r_addr];
  assign r_data2 = (r_addr2 == 5'd0) ? 32'h0 : regfile[r_addr2];

  regs_dump dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .r_addr(r_addr), .r_data(r_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done)
  );

  regs_dump #(.ADDR_W(5), .DATA_W(32), .LAST_ADDR(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .r_addr(r_addr2), .r_data(r_data2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_addr(out_addr2), .out_data(out_data2),
    .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    start2 = 1'b0; abort2 = 1'b0; out_ready2 = 1'b1;
    for (int i = 0; i < 32; i++) regfile[i] = $urandom;
    repeat (3) @(negedge clk);
    vectors++;
    if ({r_addr, out_valid, out_addr, out_data, busy, done} !== 45'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h required 0", {r_addr, out_valid, out_addr, out_data, busy, done});
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle: busy=%b valid=%b done=%b required 0 0 0", busy, out_valid, done);
      end
    end
  endtask

  task automatic test_full_scan();
    logic [31:0] snap [32];
    int got;
    for (int i = 0; i < 32; i++) regfile[i] = 32'h1000_0000 + i;
    for (int i = 0; i < 32; i++) snap[i] = (i == 0) ? 32'h0 : regfile[i];
    got = 0;
    out_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 66; c++) begin
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (out_valid !== (c % 2 == 0 && c <= 64)) begin
        miscompares++;
        $display("FAIL full_valid cycle %0d: got %b required %b", c, out_valid, (c % 2 == 0 && c <= 64));
      end
      vectors++;
      if (done !== (c == 65)) begin
        miscompares++;
        $display("FAIL full_done cycle %0d: got %b required %b", c, done, (c == 65));
      end
      vectors++;
      if (busy !== (c <= 65)) begin
        miscompares++;
        $display("FAIL full_busy cycle %0d: got %b required %b", c, busy, (c <= 65));
      end
      if (c % 2 == 1 && c <= 63) begin
        vectors++;
        if (r_addr !== 5'((c - 1) / 2)) begin
          miscompares++;
          $display("FAIL full_raddr cycle %0d: got %0d required %0d", c, r_addr, (c - 1) / 2);
        end
      end
      if (c == 65) begin
        vectors++;
        if (r_addr !== 5'd31) begin
          miscompares++;
          $display("FAIL full_nowrap: r_addr in FIN got %0d required 31", r_addr);
        end
      end
      if (out_valid === 1'b1 && got < 32) begin
        vectors++;
        if (out_addr !== 5'(got) || out_data !== snap[got]) begin
          miscompares++;
          $display("FAIL full_word: got (%0d,%h) required (%0d,%h)", out_addr, out_data, got, snap[got]);
        end
        got++;
      end
    end
    vectors++;
    if (got != 32) begin
      miscompares++;
      $display("FAIL full_count: got %0d words required 32", got);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] snap [32];
    logic [31:0] held;
    int got, stall, dones;
    for (int i = 0; i < 32; i++) regfile[i] = $urandom;
    for (int i = 0; i < 32; i++) snap[i] = (i == 0) ? 32'h0 : regfile[i];
    got = 0; stall = 0; dones = 0; held = '0;
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 400 && dones == 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) dones++;
      if (out_valid === 1'b1 && out_addr === 5'd3 && stall < 5) begin
        if (stall == 0) begin
          held = out_data;
        end else begin
          vectors++;
          if (out_data !== held) begin
            miscompares++;
            $display("FAIL bp_hold stall %0d: got (%0d,%h) required (3,%h)", stall, out_addr, out_data, held);
          end
        end
        stall++;
        out_ready = 1'b0;
      end else begin
        out_ready = ($urandom_range(0, 2) != 0);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        vectors++;
        if (got >= 32 || out_addr !== 5'(got) || out_data !== snap[got % 32]) begin
          miscompares++;
          $display("FAIL bp_word: got (%0d,%h) required (%0d,%h)", out_addr, out_data, got, snap[got % 32]);
        end
        got++;
      end
    end
    @(negedge clk);
    vectors++;
    if (got != 32 || dones != 1 || stall != 5 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_summary: words=%0d dones=%0d stalls=%0d busy=%b required 32 1 5 0", got, dones, stall, busy);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_snapshot();
    logic [31:0] snap [32];
    int got, dones;
    logic written;
    for (int i = 0; i < 32; i++) regfile[i] = $urandom;
    for (int i = 0; i < 32; i++) snap[i] = (i == 0) ? 32'h0 : regfile[i];
    got = 0; dones = 0; written = 1'b0;
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 400 && dones == 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) dones++;
      if (out_valid === 1'b1 && out_addr === 5'd4 && !written) begin
        regfile[4] = 32'hDEAD_BEEF;
        written = 1'b1;
        out_ready = 1'b0;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        vectors++;
        if (got >= 32 || out_addr !== 5'(got) || out_data !== snap[got % 32]) begin
          miscompares++;
          $display("FAIL snap_word: got (%0d,%h) required (%0d,%h)", out_addr, out_data, got, snap[got % 32]);
        end
        got++;
      end
    end
    vectors++;
    if (got != 32 || dones != 1 || !written) begin
      miscompares++;
      $display("FAIL snap_summary: words=%0d dones=%0d written=%b required 32 1 1", got, dones, written);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_abort();
    logic found;
    int dones;
    found = 1'b0; dones = 0;
    for (int i = 0; i < 32; i++) regfile[i] = $urandom;
    out_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid === 1'b1 && out_addr === 5'd10) begin
        found = 1'b1;
        abort = 1'b1;
        break;
      end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL abort_reach: SEND at address 10 not seen, got found=%b required 1", found);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || r_addr !== 5'd0) begin
      miscompares++;
      $display("FAIL abort_idle: busy=%b valid=%b done=%b r_addr=%0d required 0 0 0 0", busy, out_valid, done, r_addr);
    end
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_in_idle: busy=%b done=%b required 0 0", busy, done);
      end
    end
    abort = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || r_addr !== 5'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_restart_read: busy=%b r_addr=%0d valid=%b required 1 0 0", busy, r_addr, out_valid);
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_addr !== 5'd0 || out_data !== 32'h0) begin
      miscompares++;
      $display("FAIL abort_restart_word: got valid=%b (%0d,%h) required 1 (0,0)", out_valid, out_addr, out_data);
    end
    for (int c = 0; c < 100 && dones == 0; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dones++;
        abort = 1'b1;
      end
    end
    @(negedge clk);
    abort = 1'b0;
    vectors++;
    if (dones != 1 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_fin: dones=%0d busy=%b done=%b required 1 0 0", dones, busy, done);
    end
  endtask

  task automatic test_async_reset();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 32; i++) regfile[i] = $urandom | 32'h1;
    out_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy === 1'b1 && out_valid === 1'b0 && r_addr === 5'd7) begin
        found = 1'b1;
        break;
      end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL areset_reach: READ at address 7 not seen, got found=%b required 1", found);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({r_addr, out_valid, out_addr, out_data, busy, done} !== 45'h0) begin
      miscompares++;
      $display("FAIL areset_outputs: got %h required 0", {r_addr, out_valid, out_addr, out_data, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL areset_after: busy=%b done=%b valid=%b required 0 0 0", busy, done, out_valid);
      end
    end
  endtask

  task automatic test_ignored_start_limit();
    logic [31:0] snap [4];
    int words, dones, p;
    for (int i = 0; i < 32; i++) regfile[i] = $urandom;
    for (int i = 0; i < 4; i++) snap[i] = (i == 0) ? 32'h0 : regfile[i];
    words = 0; dones = 0;
    out_ready2 = 1'b1;
    @(negedge clk); start2 = 1'b1;
    @(posedge clk);
    // each scan: 4 words x 2 cycles, FIN, then one IDLE cycle before restarting
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      p = (c - 1) % 10;
      if (c == 30) start2 = 1'b0;
      vectors++;
      if (out_valid2 !== (p < 8 && p % 2 == 1) || done2 !== (p == 8) || busy2 !== (p != 9)) begin
        miscompares++;
        $display("FAIL limit_state cycle %0d: valid=%b done=%b busy=%b required %b %b %b",
                 c, out_valid2, done2, busy2, (p < 8 && p % 2 == 1), (p == 8), (p != 9));
      end
      if (out_valid2 === 1'b1) begin
        vectors++;
        if (out_addr2 !== 5'(p / 2) || out_data2 !== snap[(p / 2) % 4]) begin
          miscompares++;
          $display("FAIL limit_word cycle %0d: got (%0d,%h) required (%0d,%h)", c, out_addr2, out_data2, p / 2, snap[(p / 2) % 4]);
        end
        words++;
      end
      if (done2 === 1'b1) dones++;
    end
    @(negedge clk);
    vectors++;
    if (words != 12 || dones != 3 || busy2 !== 1'b0) begin
      miscompares++;
      $display("FAIL limit_summary: words=%0d dones=%0d busy=%b required 12 3 0", words, dones, busy2);
    end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_backpressure();
    test_snapshot();
    test_abort();
    test_async_reset();
    test_ignored_start_limit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
